score_display_sequencer: RTL and testbench
==========================================

SCORE_DISPLAY_SEQUENCER -- requirements
Module: score_display_sequencer

Interface
REQ-001 Parameter: ALT_PERIOD, default 25000000, clock cycles each score/high-score view is held after game over (minimum 2).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle pulse, begin new game.
REQ-005 game_over  input  1  single-cycle pulse, current game ended.
REQ-006 add_valid  input  1  points-add request.
REQ-007 add_value  input  4  points to add (0..15), sampled on accept.
REQ-008 add_ready  output  1  sequencer can accept an add.
REQ-009 digit0/digit1/digit2  output  4 each  BCD ones/tens/hundreds of displayed value, registered.
REQ-010 blank  output  3  per-digit blank (bit0 ones, bit1 tens, bit2 hundreds), registered.
REQ-011 show_high  output  1  1 = displayed value is high score, registered.
REQ-012 new_record  output  1  1 = last finished game set a new high score.
REQ-013 state  output  2  FSM state: 0 IDLE, 1 PLAY, 2 OVER_SCORE, 3 OVER_HIGH.

Function
REQ-014 Score and high score SHALL be held as 3-digit BCD registers (000..999), never binary.
REQ-015 IDLE: display high score; start -> PLAY, score cleared to 000 on the same edge.
REQ-016 add_ready SHALL equal (state==PLAY) && (pending==0) && !game_over, combinationally.
REQ-017 Accept = add_valid && add_ready at an edge; pending <= add_value on that edge.
REQ-018 While pending>0 in PLAY: each edge score += 1 (BCD carry ones->tens->hundreds in one cycle), pending -= 1.
REQ-019 Latency: add of N accepted at edge k increments at edges k+1..k+N; add_ready high again after edge k+N; add_value 0 is accepted and is a no-op.
REQ-020 Saturation: score at 999 SHALL hold 999 on further increments; pending still counts down.
REQ-021 PLAY + game_over -> OVER_SCORE; remaining pending discarded (pending <= 0); if score > high then high <= score and new_record <= 1, else new_record <= 0, same edge.
REQ-022 game_over and add_valid in the same cycle: game_over wins, no add accepted.
REQ-023 OVER_SCORE shows score, OVER_HIGH shows high; alternate after ALT_PERIOD cycles each, via alt counter reset on every state entry.
REQ-024 start in OVER_SCORE/OVER_HIGH -> PLAY: score 000, new_record 0, pending 0, alt counter 0.
REQ-025 start in PLAY and game_over outside PLAY SHALL be ignored; start and game_over together in PLAY: game_over wins.
REQ-026 show_high = 1 in IDLE and OVER_HIGH, else 0.
REQ-027 Display outputs SHALL update one cycle after the selected source register or state changes.
REQ-028 blank[2] = (hundreds==0); blank[1] = (hundreds==0 && tens==0); blank[0] = 0 always.

Reset
REQ-029 On reset: state IDLE, score 000, high 000, pending 0, alt counter 0, new_record 0, digits 0, blank 3'b110, show_high 1; add_ready 0.
REQ-030 Reset mid-add or mid-alternation SHALL abort all activity; high score is lost.

Verification
REQ-031 Reset, start, add 5 then add 7 back-to-back with add_valid held -> score 012, add_ready low 5 cycles then 7 cycles, digit0=2 digit1=1, blank=3'b100.
REQ-032 Score 995, add 9 -> score reaches 999 after 4 increments, stays 999, add_ready returns high 9 cycles after accept.
REQ-033 Score 042, high 030, game_over -> OVER_SCORE, high 042, new_record 1; after ALT_PERIOD (set 4) show_high 1, digits 042; after 4 more show_high 0.
REQ-034 Add 10 accepted, game_over 3 cycles later -> score frozen at +2 (pending discarded), add_ready 0 in OVER states.
REQ-035 game_over and add_valid same cycle in PLAY -> no add accepted, state OVER_SCORE; second game 025 < high 042 -> new_record 0, high stays 042.
REQ-036 Reset asserted mid-add of 15 in PLAY -> next cycle state IDLE, score 000, high 000, add_ready 0, blank 3'b110.

Source files
------------

// File: rtl/score_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : score_display_sequencer
//  Purpose  : Game score sequencer with BCD score/high-score registers, paced
//             point accumulation and alternating post-game display.
//  Revision : 1.0 - initial release
// ============================================================================
module score_display_sequencer #(
    parameter int ALT_PERIOD = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       game_over,
    input  logic       add_valid,
    input  logic [3:0] add_value,
    output logic       add_ready,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [2:0] blank,
    output logic       show_high,
    output logic       new_record,
    output logic [1:0] state
);

    localparam logic [1:0] c_idle       = 2'd0;
    localparam logic [1:0] c_play       = 2'd1;
    localparam logic [1:0] c_over_score = 2'd2;
    localparam logic [1:0] c_over_high  = 2'd3;

    localparam int                 c_alt_w    = $clog2(ALT_PERIOD);
    localparam logic [c_alt_w-1:0] c_alt_last = c_alt_w'(ALT_PERIOD - 1);

    logic [1:0]         state_q,      state_d;
    logic [11:0]        score_q,      score_d;
    logic [11:0]        high_q,       high_d;
    logic [3:0]         pending_q,    pending_d;
    logic [c_alt_w-1:0] alt_cnt_q,    alt_cnt_d;
    logic               new_record_q, new_record_d;
    logic [3:0]         digit0_q,     digit0_d;
    logic [3:0]         digit1_q,     digit1_d;
    logic [3:0]         digit2_q,     digit2_d;
    logic [2:0]         blank_q,      blank_d;
    logic               show_high_q,  show_high_d;

    logic               w_accept;
    logic [11:0]        w_src;

    // Saturating BCD increment; carry ripples through all three digits in one step.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        logic [3:0] hund;
        ones = v[3:0];
        tens = v[7:4];
        hund = v[11:8];
        if (v == 12'h999) begin
            return v;
        end
        if (ones == 4'd9) begin
            ones = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
                hund = hund + 4'd1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {hund, tens, ones};
    endfunction

    assign add_ready = (state_q == c_play) && (pending_q == 4'd0) && !game_over;
    assign w_accept  = add_valid && add_ready;

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        high_d       = high_q;
        pending_d    = pending_q;
        alt_cnt_d    = alt_cnt_q;
        new_record_d = new_record_q;

        case (state_q)
            c_idle: begin
                if (start) begin
                    state_d      = c_play;
                    score_d      = 12'h000;
                    pending_d    = 4'd0;
                    alt_cnt_d    = '0;
                    new_record_d = 1'b0;
                end
            end
            c_play: begin
                if (game_over) begin
                    state_d   = c_over_score;
                    pending_d = 4'd0;
                    alt_cnt_d = '0;
                    // BCD digit ordering makes a plain unsigned compare valid.
                    if (score_q > high_q) begin
                        high_d       = score_q;
                        new_record_d = 1'b1;
                    end else begin
                        new_record_d = 1'b0;
                    end
                end else if (pending_q != 4'd0) begin
                    score_d   = bcd_inc(score_q);
                    pending_d = pending_q - 4'd1;
                end else if (w_accept) begin
                    pending_d = add_value;
                end
            end
            default: begin
                if (start) begin
                    state_d      = c_play;
                    score_d      = 12'h000;
                    pending_d    = 4'd0;
                    alt_cnt_d    = '0;
                    new_record_d = 1'b0;
                end else if (alt_cnt_q == c_alt_last) begin
                    state_d   = (state_q == c_over_score) ? c_over_high : c_over_score;
                    alt_cnt_d = '0;
                end else begin
                    alt_cnt_d = alt_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Display registers follow the source selected by the current state.
    always_comb begin
        w_src       = ((state_q == c_play) || (state_q == c_over_score)) ? score_q : high_q;
        digit0_d    = w_src[3:0];
        digit1_d    = w_src[7:4];
        digit2_d    = w_src[11:8];
        blank_d     = {(w_src[11:8] == 4'd0), (w_src[11:4] == 8'd0), 1'b0};
        show_high_d = (state_q == c_idle) || (state_q == c_over_high);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= c_idle;
            score_q      <= 12'h000;
            high_q       <= 12'h000;
            pending_q    <= 4'd0;
            alt_cnt_q    <= '0;
            new_record_q <= 1'b0;
            digit0_q     <= 4'd0;
            digit1_q     <= 4'd0;
            digit2_q     <= 4'd0;
            blank_q      <= 3'b110;
            show_high_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_q       <= high_d;
            pending_q    <= pending_d;
            alt_cnt_q    <= alt_cnt_d;
            new_record_q <= new_record_d;
            digit0_q     <= digit0_d;
            digit1_q     <= digit1_d;
            digit2_q     <= digit2_d;
            blank_q      <= blank_d;
            show_high_q  <= show_high_d;
        end
    end

    assign digit0     = digit0_q;
    assign digit1     = digit1_q;
    assign digit2     = digit2_q;
    assign blank      = blank_q;
    assign show_high  = show_high_q;
    assign new_record = new_record_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_display_sequencer
//  Purpose  : Directed plus randomized checks against a decimal-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_display_sequencer;

    localparam int P = 4;

    logic       clock = 1'b0;
    logic       reset, start, game_over, add_valid;
    logic [3:0] add_value;
    logic       add_ready;
    logic [3:0] digit0, digit1, digit2;
    logic [2:0] blank;
    logic       show_high, new_record;
    logic [1:0] state;

    score_display_sequencer #(.ALT_PERIOD(P)) dut (
        .clock(clock), .reset(reset), .start(start), .game_over(game_over),
        .add_valid(add_valid), .add_value(add_value), .add_ready(add_ready),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .blank(blank),
        .show_high(show_high), .new_record(new_record), .state(state)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model state: 0 idle, 1 play, 2 over/score, 3 over/high; values are plain decimals.
    int m_state, m_score, m_high, m_pend, m_alt, m_nr;
    int m_d0, m_d1, m_d2, m_blank, m_sh;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_pend = 0; m_alt = 0; m_nr = 0;
        m_d0 = 0; m_d1 = 0; m_d2 = 0; m_blank = 6; m_sh = 1;
    endtask

    function automatic logic ready_model(input logic g);
        return (m_state == 1) && (m_pend == 0) && !g;
    endfunction

    task automatic model_update(input logic r, input logic s, input logic g,
                                input logic v, input logic [3:0] val);
        int  src;
        logic rdy;
        rdy = ready_model(g);
        if (r) begin
            model_reset();
            return;
        end
        src     = (m_state == 1 || m_state == 2) ? m_score : m_high;
        m_d0    = src % 10;
        m_d1    = (src / 10) % 10;
        m_d2    = src / 100;
        m_blank = ((m_d2 == 0) ? 4 : 0) + ((src < 10) ? 2 : 0);
        m_sh    = (m_state == 0 || m_state == 3) ? 1 : 0;
        if (m_state == 1) begin
            if (g) begin
                m_state = 2; m_pend = 0; m_alt = 0;
                if (m_score > m_high) begin m_high = m_score; m_nr = 1; end
                else m_nr = 0;
            end else if (m_pend > 0) begin
                m_score = (m_score >= 999) ? 999 : m_score + 1;
                m_pend--;
            end else if (v && rdy) begin
                m_pend = int'(val);
            end
        end else if (s) begin
            m_state = 1; m_score = 0; m_pend = 0; m_alt = 0; m_nr = 0;
        end else if (m_state >= 2) begin
            if (m_alt == P - 1) begin
                m_state = (m_state == 2) ? 3 : 2;
                m_alt   = 0;
            end else begin
                m_alt++;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic g,
                        input logic v, input logic [3:0] val);
        reset = r; start = s; game_over = g; add_valid = v; add_value = val;
        #1;
        chk("add_ready", 16'(add_ready), 16'(ready_model(g)));
        @(posedge clock);
        model_update(r, s, g, v, val);
        #1;
        chk("state",      16'(state),      16'(m_state));
        chk("digit0",     16'(digit0),     16'(m_d0));
        chk("digit1",     16'(digit1),     16'(m_d1));
        chk("digit2",     16'(digit2),     16'(m_d2));
        chk("blank",      16'(blank),      16'(m_blank));
        chk("show_high",  16'(show_high),  16'(m_sh));
        chk("new_record", 16'(new_record), 16'(m_nr));
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Accept one add (add_valid noise while busy must not be taken) and drain it.
    task automatic do_add(input int val);
        int guard;
        guard = 0;
        while (!ready_model(1'b0) && guard < 40) begin
            step(1'b0, 1'b0, 1'b0, 1'($urandom), 4'($urandom));
            guard++;
        end
        chk("add_wait_bound", 16'(guard < 40), 16'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'(val));
        while (m_pend > 0) step(1'b0, 1'b0, 1'b0, 1'($urandom), 4'($urandom));
    endtask

    task automatic add_to(input int target);
        int room;
        while (m_score < target) begin
            room = target - m_score;
            do_add($urandom_range(0, (room > 15) ? 15 : room));
        end
    endtask

    int   acc, cnt;
    int   lows [2];
    logic rdy;

    initial begin
        reset = 1'b1; start = 1'b0; game_over = 1'b0; add_valid = 1'b0; add_value = 4'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        model_reset();
        chk("rst_state",     16'(state),     16'd0);
        chk("rst_blank",     16'(blank),     16'b110);
        chk("rst_show_high", 16'(show_high), 16'd1);
        chk("rst_digits",    16'({digit2, digit1, digit0}), 16'h000);
        chk("rst_new_rec",   16'(new_record), 16'd0);
        chk("rst_add_ready", 16'(add_ready), 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Game 1: back-to-back adds of 5 then 7 with add_valid held.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        acc = 0; lows[0] = 0; lows[1] = 0;
        for (int i = 0; i < 40 && !(acc == 2 && m_pend == 0); i++) begin
            rdy = add_ready;
            if (!rdy && acc > 0) lows[acc-1]++;
            step(1'b0, 1'b0, 1'b0, 1'(acc < 2), (acc == 0) ? 4'd5 : 4'd7);
            if (rdy && acc < 2) acc++;
        end
        idle(1);
        chk("b2b_low_first",  16'(lows[0]), 16'd5);
        chk("b2b_low_second", 16'(lows[1]), 16'd7);
        chk("b2b_digit0",     16'(digit0),  16'd2);
        chk("b2b_digit1",     16'(digit1),  16'd1);
        chk("b2b_blank",      16'(blank),   16'b100);
        add_to(30);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Game 2: 042 beats 030, then alternate views.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add_to(42);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("rec_state",  16'(state),      16'd2);
        chk("rec_newrec", 16'(new_record), 16'd1);
        idle(P + 1);
        chk("alt_show_high", 16'(show_high), 16'd1);
        chk("alt_digits",    16'({digit2, digit1, digit0}), 16'h042);
        chk("over_ready",    16'(add_ready), 16'd0);
        idle(P);
        chk("alt_back_score", 16'(show_high), 16'd0);

        // Game 3: game_over collides with add_valid; 025 does not beat 042.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add_to(25);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        chk("collide_state",  16'(state),      16'd2);
        chk("collide_newrec", 16'(new_record), 16'd0);
        idle(2 * P + 2);

        // Game 4: add 10, game_over three cycles later freezes score at 2.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle(1);
        chk("freeze_digit0", 16'(digit0),    16'd2);
        chk("freeze_ready",  16'(add_ready), 16'd0);

        // Game 5: saturation at 999.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        add_to(995);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        cnt = 0;
        while (!add_ready && cnt < 30) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            cnt++;
        end
        chk("sat_ready_delay", 16'(cnt), 16'd9);
        idle(1);
        chk("sat_digits", 16'({digit2, digit1, digit0}), 16'h999);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 24) == 0), 1'($urandom), 4'($urandom));
        end

        // Reset in the middle of an add of 15.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        #1;
        chk("midrst_state",  16'(state),     16'd0);
        chk("midrst_digits", 16'({digit2, digit1, digit0}), 16'h000);
        chk("midrst_blank",  16'(blank),     16'b110);
        chk("midrst_ready",  16'(add_ready), 16'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
